// File: rtl/mux_arb_nto1_reg_pkg.sv
// Shared definitions for the N:1 registered select/arbitration mux:
// mode encodings and an elaboration-time log2 helper.
package mux_arb_nto1_reg_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Smallest r with 2**r >= value; used to validate the select width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_nto1_reg_rr_arbiter_n.sv
// Round-robin arbiter: first asserted request at or after ptr, ascending
// with wrap at N-1 -> 0. Grant outputs are suppressed while en is low.
module rr_arbiter_n
    import mux_arb_nto1_reg_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_grant
);

    int idx;

    // ptr is always kept below N by the owner, so one subtraction wraps.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant && req[idx]) begin
                any_grant   = 1'b1;
                grant_idx   = SEL_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
        if (!en) begin
            grant     = '0;
            any_grant = 1'b0;
        end
    end

endmodule

// File: rtl/mux_arb_nto1_reg.sv
// Parametrised N:1 mux with directed or round-robin source selection and a
// single full-throughput output register behind a valid/ready handshake.
module mux_arb_nto1_reg
    import mux_arb_nto1_reg_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   select,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    if (SEL_W != clog2(N) || N < 2 || N > 16) begin : g_param_check
        $error("mux_arb_nto1_reg: SEL_W must equal clog2(N) and N must be 2..16");
    end

    logic             load;
    logic             xfer;
    logic [N-1:0]     dir_ready;
    logic [N-1:0]     rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] src_idx;
    logic [WIDTH-1:0] src_data;

    assign load = !out_valid || out_ready;

    rr_arbiter_n #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .en        (load && (mode == MODE_RR) && !Reset),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    // An out-of-range select matches no index, so nothing is made ready.
    always_comb begin
        dir_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) == select) begin
                dir_ready[i] = load;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!Reset) begin
            in_ready = (mode == MODE_RR) ? rr_grant : dir_ready;
        end
        xfer    = !Reset && ((mode == MODE_RR) ? rr_any : |(in_valid & dir_ready));
        src_idx = (mode == MODE_RR) ? rr_idx : select;
    end

    always_comb begin
        src_data = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) == src_idx) begin
                src_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A load slot either captures a new word or empties the register;
    // out_data/out_src keep their last value when the register empties.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= src_data;
                out_src   <= src_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= (rr_idx == SEL_W'(N - 1)) ? '0 : rr_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_arb_nto1_reg.md
Name: mux_arb_nto1_reg

Overview:
- Parametrised successor to the fixed 4:1 5-bit select mux used in the datapath (e.g. write-register-address selection).
- Generalised in width and input count; output is registered behind a valid/ready handshake.
- Two modes: directed (external select, as before) and round-robin arbitration among valid inputs.
- Sits between multiple producers (forwarding/writeback sources, test ports) and one registered consumer.

Parameters:
WIDTH, 5, data width per input
N, 4, number of inputs (2..16, need not be a power of two)
SEL_W, 2, select/source-index width; must equal ceil(log2(N))

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-input valid
in_ready  output  N  per-input ready; combinational, at most one bit high
select  input  SEL_W  input index used in directed mode
mode  input  1  0 = directed, 1 = round-robin
out_data  output  WIDTH  registered selected data
out_src  output  SEL_W  registered index of the input that supplied out_data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word this cycle

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high (Reset).
- Reset values: out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready is all zero while Reset is high.
- load = !out_valid || out_ready. This is a single output stage with full throughput: a held word can be consumed and a new word loaded in the same cycle.
- Transfer on input i: in_valid[i] && in_ready[i]. On the next edge: out_data <= in_data[i], out_src <= i, out_valid <= 1.
- No transfer and out_ready high: out_valid <= 0. out_data and out_src keep their last values.
- Stall (out_valid && !out_ready): out_data, out_src and out_valid are held stable. in_ready is all zero.
- Latency: 1 cycle from transfer to out_valid.
- Directed mode: in_ready[select] = load, all other bits 0.
  - If select >= N, no input is ready and nothing transfers.
  - rr_ptr is unchanged in this mode.
- Round-robin mode: search in_valid starting at rr_ptr, ascending, wrapping at N-1 -> 0. The first valid index g gets in_ready[g] = load.
  - On transfer, rr_ptr <= (g == N-1) ? 0 : g+1.
  - No valid inputs: no grant, rr_ptr held.
- Mode or select changes are evaluated combinationally in the cycle they are presented. rr_ptr persists across mode switches.
- in_valid dropping before a grant is legal: the input is simply skipped.
- Reset mid-operation discards any held word (out_valid=0 on the next edge) and clears rr_ptr.
- No combinational path from in_data to out_data. in_ready depends combinationally on out_ready, out_valid, in_valid, select, mode and rr_ptr.

Decomposition:
- Shared package: MODE_DIRECT=1'b0, MODE_RR=1'b1, and a clog2 function used to check SEL_W.
- One sub-module: rr_arbiter_n. Inputs: req[N], ptr, en. Outputs: one-hot grant[N], encoded grant_idx, any_grant.
- The top level holds the output register and rr_ptr, and muxes in_data by grant_idx.

Test Plan:
1. Reset: hold Reset 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. Release -> first transfer appears on out_valid one cycle later.
2. Directed, N=4, WIDTH=5: in_data = {5'd3,5'd2,5'd1,5'd0}, select=2, in_valid=4'hF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=2, out_src=2, one word per cycle.
3. Backpressure: out_ready=0 after the first load -> out_data is held for 5 cycles and in_ready=0. Raise out_ready -> the held word is consumed and a new word is loaded the same cycle, with no bubble.
4. Round-robin fairness: mode=1, in_valid=4'hF, out_ready=1 -> out_src sequence 0,1,2,3,0. Then in_valid=4'b1010 -> 1,3,1,3.
5. Wrap and skip, non-power-of-two: N=3, SEL_W=2, rr_ptr=2, in_valid=3'b011 -> grant 0, then rr_ptr=1. In directed mode with select=3 -> no in_ready and out_valid falls to 0.
6. Reset mid-stall: out_valid=1, out_ready=0, assert Reset for 1 cycle -> out_valid=0, rr_ptr=0 on the next edge.
